// File: rtl/decode_stage_pkg.sv
// rv32_isa: RV32I opcode/ALU/immediate encodings and the decode control word.
`default_nettype none

package rv32_isa;

    localparam int RegWidth     = 32;
    localparam int RegAddrWidth = 5;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_FENCE  = 7'b0001111,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_t;

    typedef struct packed {
        alu_op_t    aluOp;
        logic [2:0] funct3;
        logic       aluSrcImm;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       illegal;
    } ctrl_t;

    function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_OP || opc == OPC_BRANCH || opc == OPC_STORE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: I/S/B/U/J immediate extraction with sign extension to XLEN.
`default_nettype none

module imm_gen
    import rv32_isa::*;
#(
    parameter int XLEN = RegWidth
) (
    input  logic [31:7]     iInstr,
    input  imm_type_t       iType,
    output logic [XLEN-1:0] oImm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (iType)
            IMM_I:   imm32 = {{20{iInstr[31]}}, iInstr[31:20]};
            IMM_S:   imm32 = {{20{iInstr[31]}}, iInstr[31:25], iInstr[11:7]};
            IMM_B:   imm32 = {{19{iInstr[31]}}, iInstr[31], iInstr[7],
                              iInstr[30:25], iInstr[11:8], 1'b0};
            IMM_U:   imm32 = {iInstr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{iInstr[31]}}, iInstr[31], iInstr[19:12],
                              iInstr[20], iInstr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign oImm = XLEN'(signed'(imm32));

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with registered valid/ready output, load-use
// bubble insertion and a saturating stall counter.
`default_nettype none

module decode_stage
    import rv32_isa::*;
#(
    parameter int XLEN          = RegWidth,
    parameter int StallCntWidth = 16
) (
    input  logic                     iClk,
    input  logic                     nRst,
    input  logic                     iValid,
    input  logic [XLEN-1:0]          iInstr,
    input  logic [XLEN-1:0]          iPC,
    output logic                     oReady,
    input  logic                     iFlush,
    input  logic                     iReady,
    output logic                     oValid,
    output logic [RegAddrWidth-1:0]  oAddr_Rs1,
    output logic [RegAddrWidth-1:0]  oAddr_Rs2,
    output logic [RegAddrWidth-1:0]  oAddr_Rd,
    output logic [XLEN-1:0]          oImm,
    output logic [XLEN-1:0]          oPC,
    output ctrl_t                    oCtrl,
    output logic [StallCntWidth-1:0] oStallCnt
);

    logic [6:0]              opcode;
    logic [2:0]              funct3;
    logic [6:0]              funct7;
    logic [RegAddrWidth-1:0] rs1, rs2, rd;
    ctrl_t                   ctrl_dec;
    imm_type_t               imm_type;
    logic [XLEN-1:0]         imm_dec;
    logic                    bad;
    logic                    hazard, accept;

    logic                     valid_q, valid_d;
    ctrl_t                    ctrl_q, ctrl_d;
    logic [XLEN-1:0]          imm_q, imm_d, pc_q, pc_d;
    logic [RegAddrWidth-1:0]  rd_q, rd_d;
    logic [StallCntWidth-1:0] stall_q, stall_d;

    assign opcode = iInstr[6:0];
    assign rd     = iInstr[11:7];
    assign funct3 = iInstr[14:12];
    assign rs1    = iInstr[19:15];
    assign rs2    = iInstr[24:20];
    assign funct7 = iInstr[31:25];

    always_comb begin
        ctrl_dec        = '0;
        ctrl_dec.aluOp  = ALU_ADD;
        ctrl_dec.funct3 = funct3;
        imm_type        = IMM_NONE;
        bad             = 1'b0;
        case (opcode)
            OPC_LUI: begin
                imm_type = IMM_U;
                ctrl_dec.aluOp     = ALU_PASSB;
                ctrl_dec.aluSrcImm = 1'b1;
                ctrl_dec.regWrite  = 1'b1;
            end
            OPC_AUIPC: begin
                imm_type = IMM_U;
                ctrl_dec.aluSrcImm = 1'b1;
                ctrl_dec.regWrite  = 1'b1;
            end
            OPC_JAL: begin
                imm_type = IMM_J;
                ctrl_dec.jump     = 1'b1;
                ctrl_dec.regWrite = 1'b1;
            end
            OPC_JALR: begin
                imm_type = IMM_I;
                ctrl_dec.jalr     = 1'b1;
                ctrl_dec.regWrite = 1'b1;
            end
            OPC_BRANCH: begin
                imm_type = IMM_B;
                ctrl_dec.aluOp  = ALU_SUB;
                ctrl_dec.branch = 1'b1;
            end
            OPC_LOAD: begin
                imm_type = IMM_I;
                ctrl_dec.memRead   = 1'b1;
                ctrl_dec.regWrite  = 1'b1;
                ctrl_dec.aluSrcImm = 1'b1;
            end
            OPC_STORE: begin
                imm_type = IMM_S;
                ctrl_dec.memWrite  = 1'b1;
                ctrl_dec.aluSrcImm = 1'b1;
            end
            OPC_OPIMM: begin
                // Shift-immediates carry funct7 in imm[11:5]; only SRAI may set bit 30.
                imm_type = IMM_I;
                ctrl_dec.aluSrcImm = 1'b1;
                ctrl_dec.regWrite  = 1'b1;
                ctrl_dec.aluOp     = alu_decode(funct3, (funct3 == 3'b101) & iInstr[30]);
                bad = ((funct3 == 3'b001) && (funct7 != 7'b0)) ||
                      ((funct3 == 3'b101) && ({funct7[6], funct7[4:0]} != 6'b0));
            end
            OPC_OP: begin
                ctrl_dec.regWrite = 1'b1;
                ctrl_dec.aluOp    = alu_decode(funct3, funct7[5]);
                bad = (funct7 != 7'b0) &&
                      !((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_FENCE: ;
            default: bad = 1'b1;
        endcase
        if (bad) begin
            ctrl_dec         = '0;
            ctrl_dec.aluOp   = ALU_ADD;
            ctrl_dec.funct3  = funct3;
            ctrl_dec.illegal = 1'b1;
            imm_type         = IMM_NONE;
        end
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .iInstr (iInstr[31:7]),
        .iType  (imm_type),
        .oImm   (imm_dec)
    );

    assign oAddr_Rs1 = rs1;
    assign oAddr_Rs2 = rs2;

    assign hazard = valid_q & ctrl_q.memRead & (rd_q != '0) & iValid &
                    ((uses_rs1(opcode) & (rs1 == rd_q)) | (uses_rs2(opcode) & (rs2 == rd_q)));
    assign oReady = nRst & (!valid_q | iReady) & !hazard;
    assign accept = iValid & oReady;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        if (iFlush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_dec;
            imm_d   = imm_dec;
            pc_d    = iPC;
            rd_d    = rd;
        end else if (iReady) begin
            valid_d = 1'b0;
        end
        stall_d = stall_q;
        if (hazard && iReady && (stall_q != '1))
            stall_d = stall_q + StallCntWidth'(1);
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            rd_q    <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            stall_q <= stall_d;
        end
    end

    assign oValid    = valid_q;
    assign oCtrl     = ctrl_q;
    assign oImm      = imm_q;
    assign oPC       = pc_q;
    assign oAddr_Rd  = rd_q;
    assign oStallCnt = stall_q;

endmodule

`default_nettype wire
